rr_mux_8_to_1: RTL
==================

// Module: rr_mux_8_to_1
//
// PURPOSE
//   8-to-1 merging multiplexer with round-robin arbitration and valid/ready handshake.
//   Collects words from 8 independent source lanes onto one output stream.
//   Tags each output word with the index of the lane it came from.
//   Reverse direction of the 1-to-8 demux: pairs with it to fan traffic back in.
//
// PARAMETERS
//   DATA_W   8   width of each lane's data word and of out_data
//
// PORTS
//   clk        in   1          single clock, all logic on rising edge
//   rst        in   1          synchronous reset, active-high
//   in_valid   in   8          per-lane request; lane i offers in_data[i*DATA_W +: DATA_W]
//   in_data    in   8*DATA_W   packed lane data, lane 0 in LSBs
//   in_ready   out  8          per-lane accept (one-hot or zero); transfer = in_valid[i] & in_ready[i]
//   out_valid  out  1          output register holds a word
//   out_data   out  DATA_W     output word
//   out_sel    out  3          source lane of out_data
//   out_ready  in   1          downstream accept; transfer = out_valid & out_ready
//
// BEHAVIOUR
//   - Reset (rst=1 at posedge): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
//     in_ready=0 while rst=1. A held word is dropped; no partial state survives.
//   - Two states:
//     - EMPTY (out_valid=0).
//     - FULL (out_valid=1).
//   - Load enable ld = ~out_valid | out_ready.
//   - Grant, combinational:
//     - When ld=1, scan lanes ptr, ptr+1, ..., ptr+7 (mod 8).
//     - g = first lane with in_valid=1; in_ready = onehot(g).
//     - When ld=0 or no lane valid: in_ready=0.
//     - in_ready may depend on in_valid. in_valid must not depend on in_ready.
//   - Cycle a grant is issued, at the next posedge:
//     - out_data <= lane g data; out_sel <= g; out_valid <= 1.
//     - ptr <= g+1 mod 8 (7 wraps to 0).
//   - ld=1 with no lane valid: out_valid <= 0; out_data/out_sel hold; ptr holds.
//   - Stall (out_valid=1, out_ready=0): out_data, out_sel, out_valid and ptr hold; in_ready=0.
//   - Latency: lane accept -> out_valid 1 cycle.
//   - Throughput: 1 word/cycle with out_ready tied high (drain and refill in the same cycle).
//   - Fairness: all 8 lanes continuously valid -> grant order 0,1,...,7,0,...
//     No lane waits more than 7 grants.
//   - A lane whose valid drops before grant is skipped without penalty.
//   - No word is duplicated or lost across back-pressure.
//
// TESTING
//   1. Reset, then in_valid=8'h04 with lane2 data=8'hA5, out_ready=1
//      -> in_ready=8'h04; next cycle out_valid=1, out_data=A5, out_sel=2; ptr=3.
//   2. in_valid=8'hFF held, out_ready=1 for 10 cycles
//      -> out_sel sequence 0,1,...,7,0,1; one word per cycle.
//   3. Lane 5 valid, out_ready=0 for 4 cycles after capture
//      -> out_data/out_sel stable, in_ready=0.
//      Then out_ready=1 -> word drains; next grant the same cycle.
//   4. ptr=7 (after a lane 6 grant), in_valid=8'h81
//      -> lane 7 granted first, then lane 0 (wrap).
//   5. rst=1 asserted while out_valid=1 and out_ready=0
//      -> next cycle out_valid=0, out_sel=0, in_ready=0.
//      First grant after release scans from lane 0.

Source files
------------

// File: rtl/rr_mux_8_to_1.sv
// 8-to-1 round-robin merging mux with valid/ready handshake.
// Each output word carries the index of the source lane it came from.
module rr_mux_8_to_1 #(
  parameter  int unsigned DATA_W  = 8,
  localparam int unsigned N_LANES = 8,
  localparam int unsigned SEL_W   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_LANES-1:0]          in_valid,
  input  logic [N_LANES*DATA_W-1:0]   in_data,
  output logic [N_LANES-1:0]          in_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [SEL_W-1:0]            out_sel,
  input  logic                        out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   ptr_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic [SEL_W-1:0]   grant;
  logic [SEL_W-1:0]   idx;
  logic [DATA_W-1:0]  data_nxt;
  logic               found;
  logic               ld;
  logic [DATA_W-1:0]  lane_data [N_LANES];

  for (genvar i = 0; i < N_LANES; i++) begin : g_unpack
    assign lane_data[i] = in_data[i*DATA_W +: DATA_W];
  end

  // First valid lane scanning upward from ptr, wrapping modulo 8.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < N_LANES; k++) begin
      idx = SEL_W'(ptr + SEL_W'(k));
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // Next-state and handshake; a grant is only issued when the output slot can be refilled.
  always_comb begin
    ld        = (state == EMPTY) || out_ready;
    in_ready  = '0;
    state_nxt = state;
    ptr_nxt   = ptr;
    data_nxt  = out_data;
    sel_nxt   = out_sel;
    if (ld && !rst) begin
      if (found) begin
        in_ready[grant] = 1'b1;
        state_nxt       = FULL;
        ptr_nxt         = SEL_W'(grant + SEL_W'(1));
        data_nxt        = lane_data[grant];
        sel_nxt         = grant;
      end else begin
        state_nxt = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      ptr      <= '0;
      out_data <= '0;
      out_sel  <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      out_data <= data_nxt;
      out_sel  <= sel_nxt;
    end
  end

  assign out_valid = (state == FULL);

endmodule
